// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Decoupled instruction-fetch front end. It issues sequential reads to a
//   1-cycle-latency instruction RAM and buffers up to DEPTH {pc, instr} pairs.
//   It hands them to IF/ID through a valid/ready handshake. A taken branch
//   (redirect) flushes the queue and restarts fetching at the new address.
//   core_start / core_end bracket the active period.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   core_start   pulse: leave IDLE and fetch from RESET_PC
//   core_end     pulse: stop fetching, discard queue, park in HALT
//   imem_req     read strobe to instruction RAM
//   imem_addr    read address (current fetch pc)
//   imem_rdata   RAM read data, valid the cycle after imem_req
//   redirect     taken branch/jump: flush and refetch
//   redirect_pc  new fetch address (low 2 bits ignored)
//   deq_valid    queue head valid
//   deq_ready    IF/ID accepts head
//   deq_instr    head instruction
//   deq_pc       head pc
//   count        occupied entries
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       core_start,
  input  logic                       core_end,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [31:0]                deq_instr,
  output logic [XLEN-1:0]            deq_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] OCC_MAX = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] r_req_addr;
  logic            r_inflight;
  logic            r_kill;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [XLEN-1:0] r_mem_pc    [DEPTH];
  logic [31:0]     r_mem_instr [DEPTH];

  logic            w_run, w_flush, w_enq, w_pop;
  logic [CW:0]     w_occ;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (core_start) w_state_nxt = S_RUN;
      S_RUN:   if (core_end)   w_state_nxt = S_HALT;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Issue / handshake
  // ---------------------------------------------------------------------------
  // The in-flight word already owns a slot, so a request only goes out when
  // stored entries plus the pending response leave room for one more.
  assign w_run     = (r_state == S_RUN);
  assign w_occ     = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_flush   = w_run & (core_end | redirect);
  assign imem_req  = w_run & (w_occ < OCC_MAX) & ~redirect;
  assign imem_addr = r_fpc;
  assign deq_valid = w_run & (r_count != '0) & ~redirect;
  assign w_pop     = deq_valid & deq_ready;
  // A response landing in a flush cycle belongs to the discarded stream.
  assign w_enq     = w_run & r_inflight & ~r_kill & ~w_flush;
  assign count     = r_count;
  assign deq_pc    = deq_valid ? r_mem_pc[r_rd_ptr]    : '0;
  assign deq_instr = deq_valid ? r_mem_instr[r_rd_ptr] : '0;

  always_comb begin
    w_count_nxt = r_count;
    if (w_enq && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_enq && w_pop) w_count_nxt = r_count - CW'(1);
  end

  // ---------------------------------------------------------------------------
  // Fetch pc, in-flight tracking, queue pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc      <= RESET_PC;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_inflight <= imem_req;
      r_kill     <= w_flush & r_inflight;
      if (imem_req) r_req_addr <= r_fpc;

      if (r_state == S_IDLE && core_start)
        r_fpc <= RESET_PC;
      else if (w_run && core_end)
        r_fpc <= r_fpc;
      else if (redirect)
        r_fpc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (imem_req)
        r_fpc <= r_fpc + PC_STEP;

      if (w_flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_count <= w_count_nxt;
        if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once
  // count says they were written, and the head outputs are gated by deq_valid.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_pc[r_wr_ptr]    <= r_req_addr;
      r_mem_instr[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH+1);
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk = 1'b0;
  logic              rst, core_start, core_end, redirect, deq_ready;
  logic [XLEN-1:0]   redirect_pc;
  logic [31:0]       imem_rdata;
  logic              imem_req, deq_valid;
  logic [XLEN-1:0]   imem_addr, deq_pc;
  logic [31:0]       deq_instr;
  logic [CW-1:0]     count;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .core_start(core_start), .core_end(core_end),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_instr(deq_instr),
    .deq_pc(deq_pc), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Instruction RAM contents: a fixed scramble of the address.
  function automatic logic [31:0] ram_f(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Reference model: mode, fetch pc, FIFO of buffered pcs, one pending request.
  typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;
  mode_t       m_mode = M_IDLE;
  bit          m_known = 0;
  logic [31:0] m_fpc;
  logic [31:0] q_pc[$];
  bit          m_pend;
  logic [31:0] m_pend_addr;

  // RAM environment and observed pop log.
  bit          ram_pend = 0;
  logic [31:0] ram_addr;
  logic [31:0] popped[$];

  // One clock cycle: drive RAM data, compare, advance model, cross the edge.
  task automatic cycle();
    bit e_req, e_valid;
    imem_rdata = ram_pend ? ram_f(ram_addr) : $urandom;
    #1;
    e_req   = (m_mode == M_RUN) && (q_pc.size() + int'(m_pend) < DEPTH) && !redirect;
    e_valid = (m_mode == M_RUN) && (q_pc.size() != 0) && !redirect;
    if (m_known) begin
      check("count", 64'(count), 64'(q_pc.size()));
      check("imem_req", 64'(imem_req), 64'(e_req));
      if (e_req) check("imem_addr", 64'(imem_addr), 64'(m_fpc));
      check("deq_valid", 64'(deq_valid), 64'(e_valid));
      if (e_valid) begin
        check("deq_pc", 64'(deq_pc), 64'(q_pc[0]));
        check("deq_instr", 64'(deq_instr), 64'(ram_f(q_pc[0])));
      end
    end
    ram_pend = (imem_req === 1'b1);
    ram_addr = imem_addr;
    if (deq_valid === 1'b1 && deq_ready) popped.push_back(deq_pc);

    if (rst) begin
      m_known = 1; m_mode = M_IDLE; m_fpc = RESET_PC; q_pc.delete(); m_pend = 0;
    end else if (m_known) begin
      case (m_mode)
        M_IDLE: begin
          if (core_start) begin m_mode = M_RUN; m_fpc = RESET_PC; end
          else if (redirect) m_fpc = redirect_pc & ~32'h3;
        end
        M_RUN: begin
          if (core_end) begin
            q_pc.delete(); m_pend = 0; m_mode = M_HALT;
          end else if (redirect) begin
            q_pc.delete(); m_pend = 0; m_fpc = redirect_pc & ~32'h3;
          end else begin
            if (e_valid && deq_ready) void'(q_pc.pop_front());
            if (m_pend) q_pc.push_back(m_pend_addr);
            m_pend = e_req;
            if (e_req) begin m_pend_addr = m_fpc; m_fpc = m_fpc + 32'd4; end
          end
        end
        default: if (redirect) m_fpc = redirect_pc & ~32'h3;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    core_start = 0; core_end = 0; redirect = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int first_valid;
    int n_pop;
    rst = 1; core_start = 0; core_end = 0; redirect = 0; redirect_pc = '0; deq_ready = 1;
    run(2);
    rst = 0;
    run(1);
    check("rst_deq_pc", 64'(deq_pc), 64'h0);
    check("rst_deq_instr", 64'(deq_instr), 64'h0);
    check("rst_addr", 64'(imem_addr), 64'(RESET_PC));

    // T1: sequential stream and start-up latency
    popped.delete();
    core_start = 1;
    cycle();
    first_valid = -1;
    for (int i = 1; i <= 6; i++) begin
      if (deq_valid === 1'b1 && first_valid < 0) first_valid = i;
      cycle();
    end
    check("t1_latency", 64'(first_valid), 64'd3);
    run(12);
    n_pop = popped.size();
    check("t1_npop", 64'(n_pop >= 14), 64'd1);

    // T2: back-pressure, then release
    deq_ready = 0;
    run(10);
    check("t2_count", 64'(count), 64'd4);
    check("t2_req", 64'(imem_req), 64'd0);
    deq_ready = 1;
    run(10);
    for (int k = 0; k < popped.size(); k++)
      check("t2_seq", 64'(popped[k]), 64'(32'(k * 4)));

    // T3: redirect with three stored entries and one in flight
    deq_ready = 0;
    for (int i = 0; i < 20 && count !== 3'd3; i++) cycle();
    check("t3_pre_count", 64'(count), 64'd3);
    popped.delete();
    redirect = 1; redirect_pc = 32'h100;
    cycle();
    check("t3_count", 64'(count), 64'd0);
    deq_ready = 1;
    run(8);
    check("t3_pop0", 64'(popped[0]), 64'h100);
    check("t3_pop1", 64'(popped[1]), 64'h104);

    // T4: redirect coincident with deq_ready, misaligned target
    popped.delete();
    redirect = 1; redirect_pc = 32'h103;
    #1 check("t4_valid", 64'(deq_valid), 64'd0);
    cycle();
    check("t4_nopop", 64'(popped.size()), 64'd0);
    run(6);
    check("t4_pop0", 64'(popped[0]), 64'h100);

    // T7: fetch pc wraps past 2^XLEN
    popped.delete();
    redirect = 1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    run(8);
    check("t7_pop0", 64'(popped[0]), 64'hFFFF_FFF8);
    check("t7_pop1", 64'(popped[1]), 64'hFFFF_FFFC);
    check("t7_pop2", 64'(popped[2]), 64'h0);
    check("t7_pop3", 64'(popped[3]), 64'h4);

    // T5: core_end mid-stream, later core_start ignored
    core_end = 1;
    cycle();
    check("t5_req", 64'(imem_req), 64'd0);
    check("t5_valid", 64'(deq_valid), 64'd0);
    core_start = 1;
    cycle();
    run(3);
    check("t5_halt_req", 64'(imem_req), 64'd0);

    // T6: reset mid-burst with a response pending
    rst = 1; cycle(); rst = 0;
    core_start = 1; cycle();
    run(6);
    check("t6_pre_req", 64'(imem_req), 64'd1);
    rst = 1; cycle(); rst = 0;
    check("t6_count", 64'(count), 64'd0);
    check("t6_valid", 64'(deq_valid), 64'd0);
    check("t6_req", 64'(imem_req), 64'd0);
    check("t6_addr", 64'(imem_addr), 64'(RESET_PC));
    check("t6_pc", 64'(deq_pc), 64'h0);
    cycle();
    check("t6_stale", 64'(count), 64'd0);
    popped.delete();
    core_start = 1; cycle();
    run(6);
    check("t6_restart", 64'(popped[0]), 64'(RESET_PC));

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      deq_ready = ($urandom_range(0, 3) != 0);
      rst = 0;
      if (m_mode == M_IDLE) core_start = ($urandom_range(0, 3) == 0);
      if (m_mode == M_HALT) rst = ($urandom_range(0, 7) == 0);
      else if ($urandom_range(0, 499) == 0) rst = 1;
      if ($urandom_range(0, 31) == 0) begin
        redirect = 1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
      end
      if (m_mode == M_RUN && $urandom_range(0, 399) == 0) core_end = 1;
      cycle();
    end
    rst = 0;
    run(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
